// File: rtl/adxl362_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adxl362_pkg
//  Description : Shared definitions for the ADXL362 SPI controller: command
//                opcodes, frame length, controller state encoding and a
//                counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package adxl362_pkg;

    // ADXL362 instruction opcodes
    localparam logic [7:0] ADXL362_WRITE_CMD = 8'h0A;
    localparam logic [7:0] ADXL362_READ_CMD  = 8'h0B;
    localparam logic [7:0] ADXL362_FIFO_CMD  = 8'h0D;

    // One transaction = command byte + address byte + data byte
    localparam int SPI_FRAME_BITS = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CS_LOW  = 2'd1,
        CS_HIGH = 2'd2
    } state_t;

    // Width of a counter that has to reach half-1; never narrower than 1 bit.
    function automatic int cnt_width(input int half);
        return (half > 2) ? $clog2(half) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adxl362_spi_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : adxl362_spi_controller_if
//  Description : Request/response handshake between user logic and the
//                ADXL362 SPI controller.
//                  start   - request a transaction (sampled when busy=0)
//                  write   - 1 = register write, 0 = register read
//                  addr    - register address
//                  wr_data - byte written in write transactions
//                  rd_data - byte captured by the last completed read
//                  busy    - transaction in progress (incl. deselect time)
//                  done    - one-cycle pulse at transaction end
//                master : user side, slave : controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface adxl362_spi_controller_if;
    logic       start;
    logic       write;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    modport master (
        output start, write, addr, wr_data,
        input  rd_data, busy, done
    );

    modport slave (
        input  start, write, addr, wr_data,
        output rd_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/spi_sclk_timer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sclk_timer
//  Description : Half-period timebase for the SPI clock. While i_en is high
//                it walks through 49 half periods of HALF clk cycles each:
//                24 low/high sclk pairs followed by one trailing low half.
//                Strobes fire in the last cycle of a half period so the
//                owner can update its registered pins on the following edge.
//  Ports       : clk, rst     - system clock, sync active-high reset
//                i_en         - run; low clears all counters
//                o_rise       - sclk should go high next cycle
//                o_fall       - sclk should go low next cycle
//                o_last       - trailing low half has elapsed
//                o_edge_cnt   - falling edges issued so far (0..24)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_timer
    import adxl362_pkg::*;
#(
    parameter int HALF = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_last,
    output logic [4:0] o_edge_cnt
);

    localparam int             CW          = cnt_width(HALF);
    localparam logic [CW-1:0]  c_cnt_max   = CW'(HALF - 1);
    // Half periods 0..47 carry the 24 bits, 48 is the trailing low time.
    localparam logic [5:0]     c_last_half = 6'(2 * SPI_FRAME_BITS);

    logic [CW-1:0] r_cnt;
    logic [5:0]    r_half;
    logic [4:0]    r_edge_cnt;
    logic          w_end;

    assign w_end      = (r_cnt == c_cnt_max);
    // Even half periods are sclk-low, odd ones sclk-high.
    assign o_rise     = i_en && w_end && !r_half[0] && (r_half != c_last_half);
    assign o_fall     = i_en && w_end &&  r_half[0];
    assign o_last     = i_en && w_end && (r_half == c_last_half);
    assign o_edge_cnt = r_edge_cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt      <= '0;
            r_half     <= '0;
            r_edge_cnt <= '0;
        end else if (w_end) begin
            r_cnt  <= '0;
            r_half <= r_half + 6'd1;
            if (r_half[0]) begin
                r_edge_cnt <= r_edge_cnt + 5'd1;
            end
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/adxl362_spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : adxl362_spi_controller
//  Description : SPI mode-0 main issuing single-register ADXL362 reads (0x0B)
//                and writes (0x0A): command, address and data byte in one
//                chip-select window, followed by a HALF-cycle deselect time.
//  Ports       : clk, rst   - system clock, sync active-high reset
//                ctrl       - request/response handshake (slave modport)
//                spi_sclk   - SPI clock, idle low
//                spi_mosi   - serial data out, MSB first
//                spi_miso   - serial data in, sampled on sclk rising edges
//                spi_cs     - active-low chip select
//  Revision    : 1.0 - initial release
// ============================================================================
module adxl362_spi_controller
    import adxl362_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000
) (
    input  logic                     clk,
    input  logic                     rst,
    adxl362_spi_controller_if.slave  ctrl,
    output logic                     spi_sclk,
    output logic                     spi_mosi,
    input  logic                     spi_miso,
    output logic                     spi_cs
);

    localparam int            HALF        = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int            CW          = cnt_width(HALF);
    localparam logic [CW-1:0] c_hold_max  = CW'(HALF - 1);
    localparam logic [4:0]    c_last_fall = 5'(SPI_FRAME_BITS - 1);

    // Strobes are generated one cycle ahead of the pin change, which needs
    // at least two cycles per half period.
    if (HALF < 2) begin : g_half_check
        $fatal(1, "adxl362_spi_controller: HALF=%0d must be >= 2", HALF);
    end

    state_t        r_state;
    logic          r_cs;
    logic          r_sclk;
    logic          r_mosi;
    logic          r_busy;
    logic          r_done;
    logic          r_write;
    // Bits still to be sent after the one currently on spi_mosi.
    logic [22:0]   r_tx_pend;
    logic [7:0]    r_rx;
    logic [7:0]    r_rd_data;
    logic [CW-1:0] r_hold;

    logic          w_en;
    logic          w_rise;
    logic          w_fall;
    logic          w_last;
    logic [4:0]    w_edge_cnt;
    logic [7:0]    w_cmd;

    assign w_en  = (r_state == CS_LOW);
    assign w_cmd = ctrl.write ? ADXL362_WRITE_CMD : ADXL362_READ_CMD;

    spi_sclk_timer #(
        .HALF (HALF)
    ) u_sclk_timer (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_en),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_last     (w_last),
        .o_edge_cnt (w_edge_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_write   <= 1'b0;
            r_tx_pend <= '0;
            r_rx      <= '0;
            r_hold    <= '0;
            // An aborted transaction leaves the previous read result intact;
            // only a reset taken while idle clears it.
            if (r_state == IDLE) begin
                r_rd_data <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ctrl.start) begin
                        r_tx_pend <= {w_cmd[6:0], ctrl.addr, ctrl.wr_data};
                        r_mosi    <= w_cmd[7];
                        r_write   <= ctrl.write;
                        r_cs      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= CS_LOW;
                    end
                end

                CS_LOW: begin
                    if (w_rise) begin
                        r_sclk <= 1'b1;
                        // Only the last 8 samples survive: cmd/addr-phase
                        // MISO bits are shifted out of the register.
                        r_rx   <= {r_rx[6:0], spi_miso};
                    end
                    if (w_fall) begin
                        r_sclk <= 1'b0;
                        if (w_edge_cnt != c_last_fall) begin
                            r_mosi    <= r_tx_pend[22];
                            r_tx_pend <= {r_tx_pend[21:0], 1'b0};
                        end
                    end
                    if (w_last) begin
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hold  <= '0;
                        r_state <= CS_HIGH;
                        if (!r_write) begin
                            r_rd_data <= r_rx;
                        end
                    end
                end

                CS_HIGH: begin
                    if (r_hold == c_hold_max) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hold <= r_hold + CW'(1);
                    end
                end

                default: begin
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign spi_cs       = r_cs;
    assign spi_sclk     = r_sclk;
    assign spi_mosi     = r_mosi;
    assign ctrl.busy    = r_busy;
    assign ctrl.done    = r_done;
    assign ctrl.rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_adxl362_spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adxl362_spi_controller
//  Description : Self-checking bench for adxl362_spi_controller with a simple
//                ADXL362-like SPI target (echoes the address on reads, random
//                MISO during command/address bytes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adxl362_spi_controller;

    localparam int HALF = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sclk, spi_mosi, spi_cs;
    logic spi_miso = 1'b0;

    adxl362_spi_controller_if u_if ();

    adxl362_spi_controller #(
        .CLK_FREQUENCY  (100_000_000),
        .SCLK_FREQUENCY (500_000)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (u_if),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs   (spi_cs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Target / monitor state
    int          win_cnt = 0, done_cnt = 0, stray_sclk = 0;
    int          win_start = 0, cs_rise_cyc = 0, last_gap = -1;
    int          m_nrise = 0, m_cslen = 0, m_rise_bad = 0;
    logic [23:0] m_rx = '0;
    logic [7:0]  m_cmd = '0, m_echo = '0;
    int          last_nrise = 0, last_cslen = 0, last_rise_bad = 0;
    logic [23:0] last_rx = '0;
    bit          have_rise = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;

    // Reference: rd_data changes only on completed reads, to the target's reply.
    logic [7:0]  exp_rd = 8'h00;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // SPI target and pin monitor, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        if (u_if.done) done_cnt++;
        if (rst) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            spi_miso  = 1'b0;
        end else begin
            if (spi_cs) begin
                if (spi_sclk && !prev_sclk) stray_sclk++;
                if (!prev_cs) begin
                    cs_rise_cyc   = cyc;
                    have_rise     = 1'b1;
                    last_rx       = m_rx;
                    last_nrise    = m_nrise;
                    last_cslen    = m_cslen;
                    last_rise_bad = m_rise_bad;
                    if (m_nrise == 24 && m_rx[23:16] == 8'h0B)
                        $display("model: Read operation, Address 0x%02h", m_rx[15:8]);
                    else if (m_nrise == 24 && m_rx[23:16] == 8'h0A)
                        $display("model: Write operation, Address 0x%02h, Data 0x%02h", m_rx[15:8], m_rx[7:0]);
                end
                spi_miso = 1'b0;
            end else begin
                if (prev_cs) begin
                    win_cnt++;
                    win_start  = cyc;
                    m_rx       = '0;
                    m_nrise    = 0;
                    m_cslen    = 0;
                    m_rise_bad = 0;
                    if (have_rise) last_gap = cyc - cs_rise_cyc;
                    spi_miso = 1'($urandom);
                end
                m_cslen++;
                if (spi_sclk && !prev_sclk) begin
                    m_rx = {m_rx[22:0], spi_mosi};
                    m_nrise++;
                    if (cyc - win_start != HALF + (m_nrise - 1) * 2 * HALF) m_rise_bad++;
                    if (m_nrise == 16) begin
                        m_cmd  = m_rx[15:8];
                        m_echo = m_rx[7:0];
                    end
                end
                if (!spi_sclk && prev_sclk) begin
                    if (m_nrise >= 16 && m_nrise < 24 && m_cmd == 8'h0B)
                        spi_miso = m_echo[23 - m_nrise];
                    else
                        spi_miso = 1'($urandom);
                end
            end
            prev_cs   = spi_cs;
            prev_sclk = spi_sclk;
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (u_if.busy && k < 60 * HALF) begin
            @(negedge clk);
            k++;
        end
    endtask

    // One transaction from a single start pulse; optional stray start pulse
    // (with a different address) poke_at cycles after acceptance.
    task automatic run_txn(input string name, input bit wr, input logic [7:0] a,
                           input logic [7:0] d, input int poke_at);
        int s_cyc, d0, k;
        bit got;
        wait_idle();
        d0 = done_cnt;
        u_if.start   = 1'b1;
        u_if.write   = wr;
        u_if.addr    = a;
        u_if.wr_data = d;
        s_cyc = cyc;
        if (!wr) exp_rd = a;
        got = 1'b0;
        for (k = 1; k <= 60 * HALF && !got; k++) begin
            @(negedge clk);
            u_if.start   = (k == poke_at);
            u_if.addr    = (k == poke_at) ? 8'h44 : 8'($urandom);
            u_if.wr_data = 8'($urandom);
            if (k != poke_at) u_if.write = 1'($urandom);
            if (u_if.done) got = 1'b1;
        end
        u_if.start = 1'b0;
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_done_lat"}, cyc - s_cyc, 1 + 49 * HALF);
        check({name, "_rd_data"}, 32'(u_if.rd_data), 32'(exp_rd));
        wait_idle();
        check({name, "_busy_lat"}, cyc - s_cyc, 50 * HALF + 1);
        @(negedge clk);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_cs_fall"}, win_start - s_cyc, 1);
        check({name, "_nrise"}, last_nrise, 24);
        check({name, "_cs_len"}, last_cslen, 49 * HALF);
        check({name, "_rise_timing"}, last_rise_bad, 0);
        check({name, "_cmd"}, 32'(last_rx[23:16]), wr ? 32'h0A : 32'h0B);
        check({name, "_addr"}, 32'(last_rx[15:8]), 32'(a));
        if (wr) check({name, "_data"}, 32'(last_rx[7:0]), 32'(d));
    endtask

    initial begin
        int k, d0, w0, s_cyc;
        bit rw;
        logic [7:0] ra, rdat;

        u_if.start = 1'b0; u_if.write = 1'b0; u_if.addr = 8'h00; u_if.wr_data = 8'h00;

        // Reset
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("rst_cs", 32'(spi_cs), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check("rst_rd_data", 32'(u_if.rd_data), 32'h00);
        repeat (1000) @(negedge clk);
        check("idle_no_sclk", stray_sclk, 0);
        check("idle_no_window", win_cnt, 0);

        // Register write
        run_txn("wr", 1'b1, 8'h1F, 8'h52, 0);

        // Stray start during an active write
        w0 = win_cnt;
        run_txn("ign", 1'b1, 8'h1F, 8'hA5, 2000);
        repeat (3 * HALF) @(negedge clk);
        check("ign_windows", win_cnt - w0, 1);

        // Register read, target echoes address
        run_txn("rd", 1'b0, 8'h2D, 8'h00, 0);

        // Back-to-back reads with start held high
        wait_idle();
        d0 = done_cnt; w0 = win_cnt;
        u_if.start = 1'b1; u_if.write = 1'b0; u_if.addr = 8'h00;
        s_cyc = cyc;
        @(negedge clk);
        u_if.addr = 8'h33;
        k = 0;
        while (!u_if.done && k < 60 * HALF) begin @(negedge clk); k++; end
        check("b2b_rd0", 32'(u_if.rd_data), 32'h00);
        k = 0;
        while (win_cnt < w0 + 2 && k < 60 * HALF) begin @(negedge clk); k++; end
        u_if.start = 1'b0;
        // cs-high time = HALF deselect cycles + the idle cycle accepting start
        check("b2b_gap", last_gap, HALF + 1);
        check("b2b_second_start", win_start - s_cyc, 50 * HALF + 2);
        @(negedge clk);
        k = 0;
        while (!u_if.done && k < 60 * HALF) begin @(negedge clk); k++; end
        check("b2b_rd1", 32'(u_if.rd_data), 32'h33);
        wait_idle();
        @(negedge clk);
        check("b2b_addr1", 32'(last_rx[15:8]), 32'h33);
        check("b2b_dones", done_cnt - d0, 2);
        exp_rd = 8'h33;

        // Reset at the 10th sclk rise of a read
        d0 = done_cnt; w0 = win_cnt;
        u_if.start = 1'b1; u_if.write = 1'b0; u_if.addr = 8'h2D;
        @(negedge clk);
        u_if.start = 1'b0;
        k = 0;
        while (!(win_cnt == w0 + 1 && m_nrise >= 10) && k < 30 * HALF) begin @(negedge clk); k++; end
        check("abort_reached_bit10", 32'(m_nrise), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", 32'(spi_cs), 32'd1);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        check("abort_busy", 32'(u_if.busy), 32'd0);
        check("abort_done", 32'(u_if.done), 32'd0);
        check("abort_rd_keep", 32'(u_if.rd_data), 32'(exp_rd));
        rst = 1'b0;
        repeat (3 * HALF) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_cs", 32'(spi_cs), 32'd1);
        run_txn("rd_after_abort", 1'b0, 8'h10, 8'h00, 0);

        // Random transactions
        for (int i = 0; i < 3; i++) begin
            rw   = 1'($urandom);
            ra   = 8'($urandom);
            rdat = 8'($urandom);
            run_txn($sformatf("rand%0d", i), rw, ra, rdat, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
